alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_pkg.sv | 22 ++
 rtl/xor64b.sv | 12 +
 rtl/alu_exec_stage.sv | 122 ++++++++++++
 tb/tb_alu_exec_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op-code encoding and output-buffer states.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_SLTU = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_ADDW = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_SUBW = 4'd9;

    typedef enum logic [1:0] {
        BufEmpty,
        BufOne,
        BufTwo
    } buf_state_e;

endpackage

// File: rtl/xor64b.sv
// Bitwise XOR of two operands.
module xor64b #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);

    assign s = a ^ b;

endmodule

// File: rtl/alu_exec_stage.sv
// Single-cycle ALU stage with an output register plus one skid entry.
// Define ALU_EXEC_STAGE_WORD_OPS_EN to enable the ADDW/SUBW word ops.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                illegal
);

    buf_state_e      state_q, state_d;
    logic [XLEN-1:0] out_res_q, out_res_d, skid_res_q, skid_res_d;
    logic            out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
    logic [XLEN-1:0] xor_res, alu_res;
    logic            alu_ill;
    logic            accept, drain;

    xor64b #(
        .W (XLEN)
    ) u_xor (
        .a (a),
        .b (b),
        .s (xor_res)
    );

`ifdef ALU_EXEC_STAGE_WORD_OPS_EN
    logic [31:0] word_add, word_sub;
    assign word_add = a[31:0] + b[31:0];
    assign word_sub = a[31:0] - b[31:0];
`endif

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = xor_res;
            OP_SLT:  alu_res = XLEN'($signed(a) < $signed(b));
            OP_SLTU: alu_res = XLEN'(a < b);
`ifdef ALU_EXEC_STAGE_WORD_OPS_EN
            OP_ADDW: alu_res = XLEN'($signed(word_add));
            OP_SUBW: alu_res = XLEN'($signed(word_sub));
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    // Both handshake outputs decode only the state flops.
    assign in_ready  = (state_q != BufTwo);
    assign out_valid = (state_q != BufEmpty);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign result    = out_res_q;
    assign illegal   = out_ill_q;

    always_comb begin
        state_d    = state_q;
        out_res_d  = out_res_q;
        out_ill_d  = out_ill_q;
        skid_res_d = skid_res_q;
        skid_ill_d = skid_ill_q;
        unique case (state_q)
            BufEmpty: begin
                if (accept) begin
                    state_d   = BufOne;
                    out_res_d = alu_res;
                    out_ill_d = alu_ill;
                end
            end
            BufOne: begin
                if (accept && drain) begin
                    out_res_d = alu_res;
                    out_ill_d = alu_ill;
                end else if (accept) begin
                    state_d    = BufTwo;
                    skid_res_d = alu_res;
                    skid_ill_d = alu_ill;
                end else if (drain) begin
                    state_d = BufEmpty;
                end
            end
            BufTwo: begin
                if (drain) begin
                    state_d   = BufOne;
                    out_res_d = skid_res_q;
                    out_ill_d = skid_ill_q;
                end
            end
            default: state_d = BufEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BufEmpty;
            out_res_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_res_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_res_q  <= out_res_d;
            out_ill_q  <= out_ill_d;
            skid_res_q <= skid_res_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized traffic
// scored against a queue-based reference model.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int cyc     = 0;
    bit rnd_ready = 1'b0;

    logic [64:0] exp_q[$];
    logic        held = 1'b0;
    logic [63:0] held_res;
    logic        held_ill;

    alu_exec_stage #(
        .XLEN (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: {illegal, result} from the op-code table.
    function automatic logic [64:0] ref_alu(input logic [3:0] o, input logic [63:0] x,
                                            input logic [63:0] y);
        logic [31:0] w;
        case (o)
            4'd0: return {1'b0, x + y};
            4'd1: return {1'b0, x - y};
            4'd2: return {1'b0, x & y};
            4'd3: return {1'b0, x | y};
            4'd4: return {1'b0, x ^ y};
            4'd5: return {1'b0, 63'd0, ($signed(x) < $signed(y))};
            4'd6: return {1'b0, 63'd0, (x < y)};
`ifdef ALU_EXEC_STAGE_WORD_OPS_EN
            4'd8: begin
                w = x[31:0] + y[31:0];
                return {1'b0, {32{w[31]}}, w};
            end
            4'd9: begin
                w = x[31:0] - y[31:0];
                return {1'b0, {32{w[31]}}, w};
            end
`endif
            default: return {1'b1, 64'd0};
        endcase
    endfunction

    // Scoreboard: handshakes are sampled mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst_n) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check_eq("hold_result", result, held_res);
                check_eq("hold_illegal", 64'(illegal), 64'(held_ill));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_result", result, e[63:0]);
                    check_eq("sb_illegal", 64'(illegal), 64'(e[64]));
                end
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_alu(op, a, b));
            held     = out_valid && !out_ready;
            held_res = result;
            held_ill = illegal;
        end
    end

    task automatic step_ready();
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one op and return 1 time unit after the edge that accepts it.
    task automatic send(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                step_ready();
                return;
            end
            @(posedge clk);
            #1;
            step_ready();
        end
        check_eq("send_timeout", 64'(in_ready), 64'd1);
    endtask

    // Idle cycle with junk on the operand lanes.
    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk);
            #1;
            step_ready();
        end
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 3))
            0: return 64'($urandom_range(0, 3));
            1: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            2: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        return ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_illegal", 64'(illegal), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        send(4'd4, 64'h0000_0000_0000_00FF, 64'h0F);
        check_eq("xor_valid", 64'(out_valid), 64'd1);
        check_eq("xor_result", result, 64'hF0);
        check_eq("xor_illegal", 64'(illegal), 64'd0);

        send(4'd1, 64'd0, 64'd1);
        check_eq("sub_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        send(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        check_eq("slt_result", result, 64'd1);
        send(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        check_eq("sltu_result", result, 64'd0);

        send(4'd15, 64'd123, 64'd456);
        check_eq("op15_result", result, 64'd0);
        check_eq("op15_illegal", 64'(illegal), 64'd1);
        send(4'd8, 64'h7FFF_FFFF, 64'd1);
`ifdef ALU_EXEC_STAGE_WORD_OPS_EN
        check_eq("addw_result", result, 64'hFFFF_FFFF_8000_0000);
        check_eq("addw_illegal", 64'(illegal), 64'd0);
`else
        check_eq("addw_result", result, 64'd0);
        check_eq("addw_illegal", 64'(illegal), 64'd1);
`endif
        idle(2);

        // Back-pressure: two entries fill, third waits for the drain.
        out_ready = 1'b0;
        send(4'd0, 64'd10, 64'd20);
        send(4'd0, 64'd30, 64'd40);
        check_eq("stall_in_ready", 64'(in_ready), 64'd0);
        op = 4'd0;
        a = 64'd50;
        b = 64'd60;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("stall_in_ready_hold", 64'(in_ready), 64'd0);
        check_eq("stall_out_valid", 64'(out_valid), 64'd1);
        check_eq("stall_head", result, 64'd30);
        out_ready = 1'b1;
        send(4'd0, 64'd50, 64'd60);
        idle(3);
        check_eq("stall_drained", 64'(exp_q.size()), 64'd0);

        // Continuous stream with out_ready held high.
        c0 = cyc;
        n0 = n_out;
        for (int i = 0; i < 256; i++) send(rnd_op(), rnd_operand(), rnd_operand());
        check_eq("stream_cycles", 64'(cyc - c0), 64'd256);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq("stream_outputs", 64'(n_out - n0), 64'd256);
        idle(2);

        // Reset while both entries are full.
        out_ready = 1'b0;
        send(4'd0, 64'd1, 64'd2);
        send(4'd0, 64'd3, 64'd4);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_result", result, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(4'd0, 64'd5, 64'd7);
        check_eq("postrst_result", result, 64'd12);
        idle(1);
        check_eq("postrst_empty", 64'(out_valid), 64'd0);

        // Randomized traffic with random back-pressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rnd_op(), rnd_operand(), rnd_operand());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check_eq("final_drained", 64'(exp_q.size()), 64'd0);
        check_eq("final_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
